pipe_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage MIPS pipeline datapath. Sits beside the datapath.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/sequencing controller for the 5-stage MIPS pipeline.
// Produces forwarding selects and the stall/flush controls. A RUN/MISS FSM
// freezes the pipe while the data cache is busy and raises a sticky
// MissTimeout if a miss waits MISS_TIMEOUT cycles.
// Optional build macro: HAZARD_PERF_EN adds PerfStall/PerfFlush/PerfMiss counters.
module pipe_hazard_ctrl #(
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             MemWriteM,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             CacheReady,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             SkipMem,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] PerfStall,
  output logic [CNT_W-1:0] PerfFlush,
  output logic [CNT_W-1:0] PerfMiss,
`endif
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MissTimeout
);

  localparam int MC_W = $clog2(MISS_TIMEOUT + 1);

  typedef enum logic {RUN, MISS} state_t;

  state_t          state_reg;
  logic [MC_W-1:0] misscnt_reg;
  logic            miss_timeout_reg;

  logic memreq;
  logic memstall;
  logic lwstall;

  assign memreq   = MemtoRegM | MemWriteM;
  assign memstall = memreq & ~CacheReady;
  assign lwstall  = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));

  // Forward selects: M stage result is newer than W, so it wins; r0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RsE != 5'd0 && RsE == WriteRegM && RegWriteM)      ForwardAE = 2'b10;
    else if (RsE != 5'd0 && RsE == WriteRegW && RegWriteW) ForwardAE = 2'b01;
    if (RtE != 5'd0 && RtE == WriteRegM && RegWriteM)      ForwardBE = 2'b10;
    else if (RtE != 5'd0 && RtE == WriteRegW && RegWriteW) ForwardBE = 2'b01;
  end

  // Stall/flush priority: cache miss freezes everything, then branch, then load-use.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    FlushW  = 1'b0;
    SkipMem = 1'b0;
    if (memstall) begin
      // E is held, so a pending branch is seen again once the cache releases.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // The D instruction is wrong-path, so a load-use stall on it is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lwstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Miss FSM with saturating wait counter and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg        <= RUN;
      misscnt_reg      <= '0;
      miss_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          misscnt_reg <= '0;
          if (memstall) state_reg <= MISS;
        end
        MISS: begin
          if (!memstall) begin
            // Release (or an unexpected drop of the request): back to RUN.
            state_reg   <= RUN;
            misscnt_reg <= '0;
          end else if (misscnt_reg != MC_W'(MISS_TIMEOUT)) begin
            misscnt_reg <= misscnt_reg + MC_W'(1);
            if (misscnt_reg == MC_W'(MISS_TIMEOUT - 1)) miss_timeout_reg <= 1'b1;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign MissTimeout = miss_timeout_reg;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_reg;
  logic [CNT_W-1:0] perf_flush_reg;
  logic [CNT_W-1:0] perf_miss_reg;

  // Free-running event counters; they wrap rather than saturate.
  always_ff @(posedge CLK) begin
    if (reset) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
      perf_miss_reg  <= '0;
    end else begin
      if (StallF)                         perf_stall_reg <= perf_stall_reg + CNT_W'(1);
      if (FlushD | FlushE)                perf_flush_reg <= perf_flush_reg + CNT_W'(1);
      if (state_reg == RUN && memstall)   perf_miss_reg  <= perf_miss_reg + CNT_W'(1);
    end
  end

  assign PerfStall = perf_stall_reg;
  assign PerfFlush = perf_flush_reg;
  assign PerfMiss  = perf_miss_reg;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: a vector table for the single-cycle cases plus
// hand-written multi-cycle sequences (cache miss, branch during miss, timeout).
// Expected output words are queued when stimulus is driven and compared at the
// following falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  logic       CLK = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegM, WriteRegW;
  logic       MemtoRegE, MemtoRegM, MemWriteM, RegWriteM, RegWriteW, PCSrcE, CacheReady;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW, SkipMem;
  logic [1:0] ForwardAE, ForwardBE;
  logic       MissTimeout;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] PerfStall, PerfFlush, PerfMiss;
`endif

  pipe_hazard_ctrl #(.MISS_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .CacheReady(CacheReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .SkipMem(SkipMem),
`ifdef HAZARD_PERF_EN
    .PerfStall(PerfStall), .PerfFlush(PerfFlush), .PerfMiss(PerfMiss),
`endif
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MissTimeout(MissTimeout)
  );

  always #5 CLK = ~CLK;

  // Output word: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW,SkipMem,ForwardAE,ForwardBE,MissTimeout}
  localparam logic [13:0] SF = 14'h2000, SD = 14'h1000, SE = 14'h0800, SM = 14'h0400;
  localparam logic [13:0] FD = 14'h0200, FE = 14'h0100, FW = 14'h0040;
  localparam logic [13:0] AM = 14'h0010, AW = 14'h0008, BM = 14'h0004, BW = 14'h0002;
  localparam logic [13:0] MT = 14'h0001;
  localparam logic [13:0] STALL = SF | SD | SE | SM | FW;

  // Flag field: {MemtoRegE,MemtoRegM,MemWriteM,RegWriteM,RegWriteW,PCSrcE,CacheReady}
  localparam logic [6:0] LDE = 7'h40, LDM = 7'h20, STM = 7'h10, RWM = 7'h08;
  localparam logic [6:0] RWW = 7'h04, BR = 7'h02, CR = 7'h01;

  typedef struct packed {
    logic [4:0] rsd, rtd, rse, rte, wrm, wrw;
    logic [6:0] fl;
  } in_t;

  typedef struct {
    in_t         in;
    logic [13:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [13:0] exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[12];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic in_t mk(input logic [4:0] rsd, rtd, rse, rte, wrm, wrw, input logic [6:0] fl);
    in_t t;
    t.rsd = rsd; t.rtd = rtd; t.rse = rse; t.rte = rte; t.wrm = wrm; t.wrw = wrw; t.fl = fl;
    return t;
  endfunction

  task automatic drive(input in_t t);
    RsD = t.rsd; RtD = t.rtd; RsE = t.rse; RtE = t.rte;
    WriteRegM = t.wrm; WriteRegW = t.wrw;
    {MemtoRegE, MemtoRegM, MemWriteM, RegWriteM, RegWriteW, PCSrcE, CacheReady} = t.fl;
  endtask

  // One pipeline cycle: drive after the edge, queue the expectation, compare mid-cycle.
  task automatic step(input string name, input in_t t, input logic rst, input logic [13:0] exp);
    sb_t e;
    sb_t got;
    logic [13:0] act;
    @(posedge CLK);
    #1;
    reset = rst;
    drive(t);
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
    @(negedge CLK);
    got = sb_q.pop_front();
    act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, SkipMem,
           ForwardAE, ForwardBE, MissTimeout};
    n_checks++;
    if (act !== got.exp) begin
      n_fail++;
      $display("FAIL %s: got %014b want %014b", got.name, act, got.exp);
    end else begin
      $display("ok   %s: %014b", got.name, act);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 7'h00));
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  in_t idle;
  in_t miss_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle    = mk(0, 0, 0, 0, 0, 0, 7'h00);
    miss_in = mk(0, 0, 0, 0, 0, 0, LDM);

    vecs[0]  = '{mk(0, 0, 0, 0, 0, 0, 7'h00),             14'h0};
    vecs[1]  = '{mk(0, 0, 5, 0, 5, 5, RWM | RWW),         AM};
    vecs[2]  = '{mk(0, 0, 0, 0, 5, 5, RWM | RWW),         14'h0};
    vecs[3]  = '{mk(0, 0, 7, 0, 7, 7, RWW),               AW};
    vecs[4]  = '{mk(0, 0, 0, 9, 3, 9, RWM | RWW),         BW};
    vecs[5]  = '{mk(0, 0, 4, 4, 4, 0, RWM),               AM | BM};
    vecs[6]  = '{mk(8, 0, 0, 8, 0, 0, LDE),               SF | SD | FE};
    vecs[7]  = '{mk(0, 0, 0, 0, 0, 0, 7'h00),             14'h0};
    vecs[8]  = '{mk(0, 8, 0, 8, 0, 0, LDE),               SF | SD | FE};
    vecs[9]  = '{mk(0, 0, 0, 0, 0, 0, LDE),               14'h0};
    vecs[10] = '{mk(8, 0, 0, 8, 0, 0, LDE | BR),          FD | FE};
    vecs[11] = '{mk(0, 0, 6, 6, 6, 6, STM | CR | RWM),    AM | BM};

    // Registers settle under reset; combinational outputs still follow the inputs.
    reset = 1'b1;
    drive(idle);
    repeat (2) @(posedge CLK);
    step("reset_comb", mk(8, 0, 0, 8, 0, 0, LDE), 1'b1, SF | SD | FE);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      step($sformatf("vec%0d", i), vecs[i].in, 1'b0, vecs[i].exp);

    // Three-cycle cache miss, release in the fourth cycle.
    do_reset();
    step("miss_c1", miss_in, 1'b0, STALL);
    step("miss_c2", miss_in, 1'b0, STALL);
    step("miss_c3", miss_in, 1'b0, STALL);
    step("miss_release", mk(0, 0, 0, 0, 0, 0, LDM | CR), 1'b0, 14'h0);
`ifdef HAZARD_PERF_EN
    @(posedge CLK);
    #1;
    drive(idle);
    check_val("perf_miss", 32'(PerfMiss), 32'd1);
    check_val("perf_stall", 32'(PerfStall), 32'd3);
`endif
    step("miss_after", idle, 1'b0, 14'h0);

    // Branch and load-use during a miss are suppressed until release.
    do_reset();
    step("br_miss_c1", mk(8, 0, 0, 8, 0, 0, LDM | BR | LDE), 1'b0, STALL);
    step("br_miss_c2", mk(8, 0, 0, 8, 0, 0, LDM | BR | LDE), 1'b0, STALL);
    step("br_release", mk(8, 0, 0, 8, 0, 0, LDM | BR | LDE | CR), 1'b0, FD | FE);
`ifdef HAZARD_PERF_EN
    @(posedge CLK);
    #1;
    drive(idle);
    check_val("perf_flush", 32'(PerfFlush), 32'd1);
`endif
    step("br_after", idle, 1'b0, 14'h0);

    // Timeout: first cycle is in RUN, then four waiting MISS cycles set the flag.
    do_reset();
    for (int c = 1; c <= 10; c++)
      step($sformatf("tmo_c%0d", c), miss_in, 1'b0, (c <= 5) ? STALL : (STALL | MT));
    step("tmo_release", mk(0, 0, 0, 0, 0, 0, LDM | CR), 1'b0, MT);
    step("tmo_sticky", idle, 1'b0, MT);
    step("tmo_miss2_c1", miss_in, 1'b0, STALL | MT);
    step("tmo_miss2_c2", miss_in, 1'b0, STALL | MT);
    step("tmo_reset_in_miss", miss_in, 1'b1, STALL | MT);
    step("tmo_cleared", idle, 1'b0, 14'h0);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
